// File: rtl/spi_flash_pkg.sv
// Shared constants and FSM encoding for the SPI flash word cache; prefetch states exist only
// when SPI_FLASH_CACHE_PREFETCH_EN is defined.
package spi_flash_pkg;

    localparam int ADDR_W = 24;
    localparam logic [7:0] FLASH_READ_OP = 8'h03;

    // Byte-offset width inside a word (OFF).
    function automatic int addr_off(input int word_byte_len);
        return $clog2(word_byte_len);
    endfunction

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOOKUP  = 4'd1,
        ST_REQ     = 4'd2,
        ST_ACK     = 4'd3,
        ST_WAIT    = 4'd4,
        ST_RESPOND = 4'd5
`ifdef SPI_FLASH_CACHE_PREFETCH_EN
        ,
        ST_PF_REQ  = 4'd6,
        ST_PF_ACK  = 4'd7,
        ST_PF_WAIT = 4'd8
`endif
    } state_t;

endpackage

// File: rtl/spi_flash_cache_array.sv
// Tag/data/valid storage, one word per line: combinational read port, synchronous write port.
// Clear-all drops every valid bit on the edge; a same-edge write then sets its own valid bit.
module spi_flash_cache_array #(
    parameter int ENTRIES = 8,
    parameter int TAG_W   = 19,
    parameter int DW      = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic [$clog2(ENTRIES)-1:0] rd_idx,
    output logic                       rd_valid,
    output logic [TAG_W-1:0]           rd_tag,
    output logic [DW-1:0]              rd_data,
    input  logic                       wr_en,
    input  logic [$clog2(ENTRIES)-1:0] wr_idx,
    input  logic                       wr_valid,
    input  logic [TAG_W-1:0]           wr_tag,
    input  logic [DW-1:0]              wr_data
);
    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem  [ENTRIES];
    logic [DW-1:0]      data_mem [ENTRIES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else begin
            if (clr) begin
                valid <= '0;
            end
            if (wr_en) begin
                valid[wr_idx] <= wr_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/spi_flash_cache.sv
// Direct-mapped read-only word cache in front of the SPI flash reader: hit answers 2 cycles after request,
// miss after 3 cycles plus the flash read; CPU holds cpu_valid until cpu_ready. Next-word prefetch via SPI_FLASH_CACHE_PREFETCH_EN.
module spi_flash_cache
    import spi_flash_pkg::*;
#(
    parameter int WORD_BYTE_LEN = 4,
    parameter int ENTRIES       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_valid,
    input  logic [ADDR_W-1:0]          cpu_addr,
    output logic                       cpu_ready,
    output logic [WORD_BYTE_LEN*8-1:0] cpu_rdata,
    input  logic                       invalidate,
    output logic [ADDR_W-1:0]          flash_address,
    output logic                       flash_valid,
    input  logic                       flash_ready,
    input  logic [WORD_BYTE_LEN*8-1:0] flash_data,
    output logic [15:0]                hit_count,
    output logic [15:0]                miss_count
);
    localparam int OFF   = addr_off(WORD_BYTE_LEN);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - OFF - IDX;
    localparam int DW    = WORD_BYTE_LEN * 8;

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [IDX-1:0]    line_idx;
    logic [TAG_W-1:0]  line_tag, rd_tag;
    logic [DW-1:0]     rd_data;
    logic              rd_valid, hit, inv_seen, inv_seen_d;
    logic              load_addr, load_faddr, set_fv, clr_fv, load_hit, load_fill;
    logic              wr_en, hit_inc, miss_inc;
    logic              unused_low;
`ifdef SPI_FLASH_CACHE_PREFETCH_EN
    logic              pf_pending, step_addr;
`endif

    assign line_idx   = addr_q[OFF+IDX-1:OFF];
    assign line_tag   = addr_q[ADDR_W-1:OFF+IDX];
    assign hit        = rd_valid && (rd_tag == line_tag);
    assign unused_low = ^cpu_addr[OFF-1:0];

    // A fill whose window saw an invalidate still answers the CPU but must not become valid.
    spi_flash_cache_array #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .DW(DW)) u_array (
        .clk      (clk),
        .reset    (reset),
        .clr      (invalidate),
        .rd_idx   (line_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (line_idx),
        .wr_valid (!(inv_seen || invalidate)),
        .wr_tag   (line_tag),
        .wr_data  (flash_data)
    );

    always_comb begin
        state_d    = state;
        load_addr  = 1'b0;
        load_faddr = 1'b0;
        set_fv     = 1'b0;
        clr_fv     = 1'b0;
        load_hit   = 1'b0;
        load_fill  = 1'b0;
        wr_en      = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
`ifdef SPI_FLASH_CACHE_PREFETCH_EN
        step_addr  = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (cpu_valid) begin
                    load_addr = 1'b1;
                    state_d   = ST_LOOKUP;
                end
`ifdef SPI_FLASH_CACHE_PREFETCH_EN
                else if (pf_pending && !hit) begin
                    load_faddr = 1'b1;
                    state_d    = ST_PF_REQ;
                end
`endif
            end
            ST_LOOKUP: begin
                if (hit) begin
                    load_hit = 1'b1;
                    hit_inc  = 1'b1;
                    state_d  = ST_RESPOND;
                end else begin
                    load_faddr = 1'b1;
                    miss_inc   = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: if (flash_ready) begin
                set_fv  = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: if (!flash_ready) begin
                clr_fv  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: if (flash_ready) begin
                wr_en     = 1'b1;
                load_fill = 1'b1;
                state_d   = ST_RESPOND;
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
`ifdef SPI_FLASH_CACHE_PREFETCH_EN
                step_addr = pf_pending;
`endif
            end
`ifdef SPI_FLASH_CACHE_PREFETCH_EN
            ST_PF_REQ: if (flash_ready) begin
                set_fv  = 1'b1;
                state_d = ST_PF_ACK;
            end
            ST_PF_ACK: if (!flash_ready) begin
                clr_fv  = 1'b1;
                state_d = ST_PF_WAIT;
            end
            ST_PF_WAIT: if (flash_ready) begin
                wr_en = 1'b1;
                if (cpu_valid) begin
                    load_addr = 1'b1;
                    state_d   = ST_LOOKUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        inv_seen_d = (state == ST_IDLE || state_d == ST_LOOKUP) ? 1'b0 : (inv_seen || invalidate);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            inv_seen      <= 1'b0;
            cpu_ready     <= 1'b0;
            cpu_rdata     <= '0;
            flash_address <= '0;
            flash_valid   <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            state     <= state_d;
            inv_seen  <= inv_seen_d;
            cpu_ready <= (state_d == ST_RESPOND);
            if (load_addr) begin
                addr_q <= {cpu_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
            end
`ifdef SPI_FLASH_CACHE_PREFETCH_EN
            else if (step_addr) begin
                addr_q <= addr_q + ADDR_W'(WORD_BYTE_LEN);
            end
`endif
            if (load_faddr) begin
                flash_address <= addr_q;
            end
            if (set_fv) begin
                flash_valid <= 1'b1;
            end else if (clr_fv) begin
                flash_valid <= 1'b0;
            end
            if (load_hit) begin
                cpu_rdata <= rd_data;
            end else if (load_fill) begin
                cpu_rdata <= flash_data;
            end
            if (hit_inc && hit_count != 16'hFFFF) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss_inc && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end

`ifdef SPI_FLASH_CACHE_PREFETCH_EN
    // Armed by a completed miss; the single IDLE cycle after RESPOND decides whether to prefetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pf_pending <= 1'b0;
        end else if (state == ST_WAIT && flash_ready) begin
            pf_pending <= 1'b1;
        end else if (state == ST_IDLE) begin
            pf_pending <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_flash_cache.sv
// Directed bench for spi_flash_cache with a line-level cache model and a responding flash reader.
module tb_spi_flash_cache;
    localparam int WBL = 4;
    localparam int ENT = 8;

    logic        clk = 1'b0;
    logic        reset, cpu_valid, invalidate, flash_ready, flash_valid, cpu_ready;
    logic [23:0] cpu_addr, flash_address;
    logic [31:0] cpu_rdata, flash_data;
    logic [15:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;

    // Model state: line contents by index, expected counters and flash request total.
    bit          m_valid [ENT];
    int          m_tag   [ENT];
    int          m_hits, m_misses, m_reqs;
    logic [31:0] exp_rdata;
    bit          in_txn;
    int          freq_count;
    int          fcnt;
    logic [23:0] last_faddr;

    always #5 clk = ~clk;

    spi_flash_cache #(.WORD_BYTE_LEN(WBL), .ENTRIES(ENT)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_valid     (cpu_valid),
        .cpu_addr      (cpu_addr),
        .cpu_ready     (cpu_ready),
        .cpu_rdata     (cpu_rdata),
        .invalidate    (invalidate),
        .flash_address (flash_address),
        .flash_valid   (flash_valid),
        .flash_ready   (flash_ready),
        .flash_data    (flash_data),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        return ({8'h00, a} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic int idx_of(input logic [23:0] a);
        int av;
        av = int'({8'h00, a});
        return (av / WBL) % ENT;
    endfunction

    function automatic int tag_of(input logic [23:0] a);
        int av;
        av = int'({8'h00, a});
        return av / (WBL * ENT);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Flash reader: accepts a request while idle, busy for a few cycles, then returns the word.
    initial begin
        flash_ready = 1'b1;
        flash_data  = '0;
        fcnt        = 0;
        freq_count  = 0;
        last_faddr  = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                flash_ready = 1'b1;
                fcnt        = 0;
            end else if (flash_ready && flash_valid) begin
                flash_ready = 1'b0;
                fcnt        = 3;
                last_faddr  = flash_address;
                freq_count++;
            end else if (!flash_ready) begin
                if (fcnt == 0) begin
                    flash_data  = mem_word(last_faddr);
                    flash_ready = 1'b1;
                end else begin
                    fcnt--;
                end
            end
        end
    end

    // Every response must belong to an open request and carry the model's word.
    always @(negedge clk) begin
        if (reset && cpu_ready) begin
            check("ready_in_txn", 32'(in_txn), 32'd1);
            check("rdata", cpu_rdata, exp_rdata);
        end
    end

    task automatic cpu_read(input logic [23:0] a, input bit inv_mid, input string nm);
        logic [23:0] wa;
        int          ix, tg, lat;
        bit          exp_hit;
        wa        = {a[23:2], 2'b00};
        ix        = idx_of(a);
        tg        = tag_of(a);
        exp_hit   = m_valid[ix] && (m_tag[ix] == tg);
        exp_rdata = mem_word(wa);
        @(negedge clk);
        cpu_addr  = a;
        cpu_valid = 1'b1;
        in_txn    = 1'b1;
        lat       = 0;
        do begin
            @(negedge clk);
            lat++;
            invalidate = inv_mid && (lat == 5);
        end while (!cpu_ready && lat < 200);
        cpu_valid  = 1'b0;
        invalidate = 1'b0;
        check({nm, "_ready_seen"}, 32'(cpu_ready), 32'd1);
        // Responder holds ready low for 5 negedges, so a miss answers on the 8th.
        if (exp_hit) check({nm, "_hit_latency"}, lat, 2);
        else         check({nm, "_miss_latency"}, lat, 8);
        if (!exp_hit) check({nm, "_flash_addr"}, 32'(last_faddr), 32'(wa));
        if (inv_mid) for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
        if (exp_hit) begin
            m_hits++;
        end else begin
            m_misses++;
            m_reqs++;
            m_valid[ix] = !inv_mid;
            m_tag[ix]   = tg;
        end
        @(negedge clk);
        in_txn = 1'b0;
`ifdef SPI_FLASH_CACHE_PREFETCH_EN
        if (!exp_hit) begin
            logic [23:0] pa;
            pa = wa + 24'd4;
            if (!(m_valid[idx_of(pa)] && m_tag[idx_of(pa)] == tag_of(pa))) begin
                m_valid[idx_of(pa)] = 1'b1;
                m_tag[idx_of(pa)]   = tag_of(pa);
                m_reqs++;
            end
        end
`endif
        repeat (16) @(negedge clk);
        check({nm, "_flash_reqs"}, freq_count, m_reqs);
        check({nm, "_hit_count"}, 32'(hit_count), m_hits);
        check({nm, "_miss_count"}, 32'(miss_count), m_misses);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] tbl [4];
        int          lat;
        reset      = 1'b1;
        cpu_valid  = 1'b0;
        cpu_addr   = '0;
        invalidate = 1'b0;
        in_txn     = 1'b0;
        m_reqs     = 0;
        model_reset();
        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 0);
        check("rst_flash_valid", 32'(flash_valid), 0);
        check("rst_hit_count", 32'(hit_count), 0);
        check("rst_miss_count", 32'(miss_count), 0);
        check("rst_flash_address", 32'(flash_address), 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        reset = 1'b1;

        cpu_read(24'h000100, 1'b0, "cold");
        check("cold_miss_lit", 32'(miss_count), 1);
        cpu_read(24'h000102, 1'b0, "hit");
        check("hit_count_lit", 32'(hit_count), 1);

        cpu_read(24'h000000, 1'b0, "conf0");
        cpu_read(24'h000020, 1'b0, "conf1");
        cpu_read(24'h000000, 1'b0, "conf2");
        check("conflict_miss_lit", 32'(miss_count), 4);

        cpu_read(24'h000040, 1'b1, "inv_fill");
        cpu_read(24'h000040, 1'b0, "inv_reread");
        check("inv_reread_miss_lit", 32'(miss_count), 6);

        tbl = '{24'hABCDE7, 24'hABCDE4, 24'h7FFFF8, 24'hABCDE5};
        for (int i = 0; i < 4; i++) cpu_read(tbl[i], 1'b0, "table");

        // Async reset while the flash request is outstanding.
        @(negedge clk);
        cpu_addr  = 24'h000080;
        cpu_valid = 1'b1;
        lat       = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!flash_valid && lat < 50);
        check("arst_reached_req", 32'(flash_valid), 1);
        #2 reset = 1'b0;
        #1;
        check("arst_cpu_ready", 32'(cpu_ready), 0);
        check("arst_flash_valid", 32'(flash_valid), 0);
        check("arst_hit_count", 32'(hit_count), 0);
        check("arst_miss_count", 32'(miss_count), 0);
        cpu_valid = 1'b0;
        m_reqs++;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cpu_read(24'h000080, 1'b0, "post_rst");
        check("post_rst_miss_lit", 32'(miss_count), 1);

`ifdef SPI_FLASH_CACHE_PREFETCH_EN
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cpu_read(24'hFFFFFC, 1'b0, "pf_wrap");
        check("pf_wrap_addr_lit", 32'(last_faddr), 32'h000000);
        cpu_read(24'h000000, 1'b0, "pf_hit");
        check("pf_hit_lit", 32'(hit_count), 1);
        check("pf_miss_lit", 32'(miss_count), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
